// File: rtl/mem_stage_pkg.sv
// Shared widths, FSM encoding and MEM/WB payload for the memory stage.
// Optional alignment checking is enabled with the MEM_ALIGN_CHECK_EN macro.
package mem_stage_pkg;

    localparam int unsigned REGISTER_LEN  = 32;
    localparam int unsigned ADDRESS_LEN   = 32;
    localparam int unsigned SRAM_ADDR_LEN = 18;
    localparam int unsigned SRAM_DATA_LEN = 16;
    localparam int unsigned WORD_IDX_LEN  = SRAM_ADDR_LEN - 1;
    localparam int unsigned CNT_LEN       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    typedef struct packed {
        logic                    wb_enable;
        logic                    mem_read;
        logic [3:0]              dest;
        logic [REGISTER_LEN-1:0] alu_res;
        logic [REGISTER_LEN-1:0] mem_data;
        logic                    align_fault;
    } memwb_t;

endpackage

// File: rtl/mem_stage_sram_controller.sv
// Two-halfword SRAM access sequencer: FSM, wait counter, SRAM pins, read assembly, ready.
// A mem op arriving in IDLE already occupies the first LO cycle.
module mem_stage_sram_controller
    import mem_stage_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_start,
    input  logic                     i_write,
    input  logic                     i_load,
    input  logic [WORD_IDX_LEN-1:0]  i_word,
    input  logic [REGISTER_LEN-1:0]  i_wdata,
    input  logic [SRAM_DATA_LEN-1:0] i_sram_rdata,
    output logic                     o_ready,
    output logic                     o_done,
    output logic [REGISTER_LEN-1:0]  o_rdata,
    output logic [SRAM_ADDR_LEN-1:0] o_sram_addr,
    output logic [SRAM_DATA_LEN-1:0] o_sram_wdata,
    output logic                     o_sram_oe,
    output logic                     o_sram_we_n
);

    mem_state_e                 r_state;
    mem_state_e                 w_cur;
    mem_state_e                 w_next;
    logic [CNT_LEN-1:0]         r_cnt;
    logic [CNT_LEN-1:0]         w_cnt_next;
    logic [SRAM_DATA_LEN-1:0]   r_lo;
    logic [SRAM_DATA_LEN-1:0]   r_hi;
    logic                       w_last;

    assign w_cur  = (r_state == ST_IDLE && i_start) ? ST_LO : r_state;
    assign w_last = (r_cnt == CNT_LEN'(WAIT_CYCLES));

    // State and wait-counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state; counter clears on every state change
    always_comb begin
        w_next     = w_cur;
        w_cnt_next = '0;
        case (w_cur)
            ST_IDLE: w_next = ST_IDLE;
            ST_LO:   w_next = w_last ? ST_HI : ST_LO;
            ST_HI:   w_next = w_last ? ST_DONE : ST_HI;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        if ((w_cur == ST_LO || w_cur == ST_HI) && w_next == w_cur)
            w_cnt_next = r_cnt + CNT_LEN'(1);
    end

    // SRAM pins and handshake
    always_comb begin
        o_ready      = 1'b0;
        o_done       = 1'b0;
        o_sram_addr  = '0;
        o_sram_wdata = '0;
        o_sram_oe    = 1'b0;
        o_sram_we_n  = 1'b1;
        case (w_cur)
            ST_IDLE: o_ready = 1'b1;
            ST_LO: begin
                o_sram_addr = {i_word, 1'b0};
                if (i_write) begin
                    o_sram_oe    = 1'b1;
                    o_sram_wdata = i_wdata[15:0];
                    o_sram_we_n  = w_last;
                end
            end
            ST_HI: begin
                o_sram_addr = {i_word, 1'b1};
                if (i_write) begin
                    o_sram_oe    = 1'b1;
                    o_sram_wdata = i_wdata[31:16];
                    o_sram_we_n  = w_last;
                end
            end
            ST_DONE: begin
                o_ready = 1'b1;
                o_done  = 1'b1;
            end
            default: o_ready = 1'b0;
        endcase
    end

    // Capture each read half on the last cycle of its phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lo <= '0;
            r_hi <= '0;
        end else if (i_load && w_last) begin
            if (w_cur == ST_LO) r_lo <= i_sram_rdata;
            if (w_cur == ST_HI) r_hi <= i_sram_rdata;
        end
    end

    assign o_rdata = {r_hi, r_lo};

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: address mapping, alignment check and MEM/WB register.
// Define MEM_ALIGN_CHECK_EN to trap misaligned loads/stores instead of ignoring bits [1:0].
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned ADDR_OFFSET = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_enable_in,
    input  logic                     mem_read_in,
    input  logic                     mem_write_in,
    input  logic [3:0]               dest_in,
    input  logic [REGISTER_LEN-1:0]  alu_res_in,
    input  logic [REGISTER_LEN-1:0]  val_rm_in,
    output logic                     ready,
    output logic                     wb_enable_out,
    output logic                     mem_read_out,
    output logic [3:0]               dest_out,
    output logic [REGISTER_LEN-1:0]  alu_res_out,
    output logic [REGISTER_LEN-1:0]  mem_data_out,
    output logic [SRAM_ADDR_LEN-1:0] sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_wdata,
    input  logic [SRAM_DATA_LEN-1:0] sram_rdata,
    output logic                     sram_oe,
    output logic                     sram_we_n,
    output logic                     align_fault
);

    logic [WORD_IDX_LEN-1:0] w_word;
    logic [1:0]              w_offs_unused;
    logic                    w_mem_op;
    logic                    w_misalign;
    logic                    w_start;
    logic                    w_load;
    logic                    w_done;
    logic [REGISTER_LEN-1:0] w_rdata;
    memwb_t                  r_memwb;

    // Only offset bits [18:0] matter after the wrap to 2^18 halfwords
    assign {w_word, w_offs_unused} = alu_res_in[18:0] - 19'(ADDR_OFFSET);

    assign w_mem_op = mem_read_in | mem_write_in;
    assign w_load   = mem_read_in & ~mem_write_in;
`ifdef MEM_ALIGN_CHECK_EN
    assign w_misalign = w_mem_op && (alu_res_in[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif
    assign w_start = w_mem_op & ~w_misalign;

    mem_stage_sram_controller #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_sram_ctrl (
        .clk          (clk),
        .rst          (rst),
        .i_start      (w_start),
        .i_write      (mem_write_in),
        .i_load       (w_load),
        .i_word       (w_word),
        .i_wdata      (val_rm_in),
        .i_sram_rdata (sram_rdata),
        .o_ready      (ready),
        .o_done       (w_done),
        .o_rdata      (w_rdata),
        .o_sram_addr  (sram_addr),
        .o_sram_wdata (sram_wdata),
        .o_sram_oe    (sram_oe),
        .o_sram_we_n  (sram_we_n)
    );

    // MEM/WB register advances only when the stage is not stalling
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_memwb <= '0;
        end else if (ready) begin
            r_memwb.wb_enable   <= wb_enable_in & ~w_misalign;
            r_memwb.mem_read    <= mem_read_in;
            r_memwb.dest        <= dest_in;
            r_memwb.alu_res     <= alu_res_in;
            r_memwb.mem_data    <= (w_done && w_load) ? w_rdata : '0;
            r_memwb.align_fault <= w_misalign;
        end
    end

    assign wb_enable_out = r_memwb.wb_enable;
    assign mem_read_out  = r_memwb.mem_read;
    assign dest_out      = r_memwb.dest;
    assign alu_res_out   = r_memwb.alu_res;
    assign mem_data_out  = r_memwb.mem_data;
    assign align_fault   = r_memwb.align_fault;

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage with a behavioural 16-bit SRAM.
// Honours MEM_ALIGN_CHECK_EN for the misaligned-access step.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_enable_in, mem_read_in, mem_write_in;
    logic [3:0]  dest_in;
    logic [31:0] alu_res_in, val_rm_in;
    logic        ready, wb_enable_out, mem_read_out, align_fault;
    logic [3:0]  dest_out;
    logic [31:0] alu_res_out, mem_data_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_oe, sram_we_n;

    typedef struct {
        logic        wb;
        logic        rd;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] data;
        logic        chk_data;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [33:0] wlog[$];
    logic [15:0] sram_mem [0:262143];
    logic [31:0] shadow [int];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_OFFSET(1024), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .wb_enable_in(wb_enable_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .dest_in(dest_in), .alu_res_in(alu_res_in), .val_rm_in(val_rm_in),
        .ready(ready), .wb_enable_out(wb_enable_out), .mem_read_out(mem_read_out),
        .dest_out(dest_out), .alu_res_out(alu_res_out), .mem_data_out(mem_data_out),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .sram_oe(sram_oe), .sram_we_n(sram_we_n), .align_fault(align_fault)
    );

    // Behavioural SRAM: asynchronous read, write captured at the clock edge
    assign sram_rdata = sram_mem[sram_addr];
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
    always @(negedge clk) if (!sram_we_n) wlog.push_back({sram_addr, sram_wdata});

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int widx(input logic [31:0] alu);
        logic [31:0] offs;
        offs = alu - 32'd1024;
        return int'(offs[18:2]);
    endfunction

    function automatic logic [31:0] shadow_rd(input logic [31:0] alu);
        return shadow.exists(widx(alu)) ? shadow[widx(alu)] : 32'h0;
    endfunction

    // Drive one instruction, push its expectation, wait for the register load and compare
    task automatic run(input logic wb, input logic rd, input logic wr, input logic [3:0] dest,
                       input logic [31:0] alu, input logic [31:0] rm, input exp_t e);
        int   lat;
        exp_t got;
        wb_enable_in = wb; mem_read_in = rd; mem_write_in = wr;
        dest_in = dest; alu_res_in = alu; val_rm_in = rm;
        sb.push_back(e);
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (ready) break;
            if (lat > 20) break;
        end
        @(posedge clk); #1;
        got = sb.pop_front();
        check("latency", 32'(lat), 32'(got.lat));
        check("wb_enable_out", 32'(wb_enable_out), 32'(got.wb));
        check("mem_read_out", 32'(mem_read_out), 32'(got.rd));
        check("dest_out", 32'(dest_out), 32'(got.dest));
        check("alu_res_out", alu_res_out, got.alu);
        if (got.chk_data) check("mem_data_out", mem_data_out, got.data);
        check("align_fault", 32'(align_fault), 32'(got.fault));
        wb_enable_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask

    function automatic exp_t mk(input logic wb, input logic rd, input logic [3:0] dest,
                                input logic [31:0] alu, input logic [31:0] data,
                                input logic chk, input logic fault, input int lat);
        exp_t e;
        e.wb = wb; e.rd = rd; e.dest = dest; e.alu = alu; e.data = data;
        e.chk_data = chk; e.fault = fault; e.lat = lat;
        return e;
    endfunction

    task automatic store(input logic [31:0] alu, input logic [31:0] val);
        wlog.delete();
        run(1'b0, 1'b0, 1'b1, 4'd0, alu, val, mk(1'b0, 1'b0, 4'd0, alu, 32'h0, 1'b1, 1'b0, 5));
        shadow[widx(alu)] = val;
    endtask

    task automatic load(input logic [3:0] dest, input logic [31:0] alu);
        run(1'b1, 1'b1, 1'b0, dest, alu, 32'h0,
            mk(1'b1, 1'b1, dest, alu, shadow_rd(alu), 1'b1, 1'b0, 5));
    endtask

    initial begin
        for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
        rst = 1'b0;
        wb_enable_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        dest_in = 4'd0; alu_res_in = 32'h0; val_rm_in = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst ready", 32'(ready), 32'd1);
        check("rst we_n", 32'(sram_we_n), 32'd1);
        check("rst oe", 32'(sram_oe), 32'd0);
        check("rst addr", 32'(sram_addr), 32'd0);
        check("rst outputs", {wb_enable_out, mem_read_out, align_fault, dest_out, 25'd0} | alu_res_out | mem_data_out, 32'h0);
        @(posedge clk); #1;

        // Plain ALU op passes in one cycle
        run(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0, mk(1'b1, 1'b0, 4'd3, 32'h55, 32'h0, 1'b1, 1'b0, 1));

        // Store: halfwords at 4 and 5 with one strobe each
        store(32'd1032, 32'hDEADBEEF);
        check("str strobes", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("str lo", 32'(wlog[0]), 32'({18'd4, 16'hBEEF}));
            check("str hi", 32'(wlog[1]), 32'({18'd5, 16'hDEAD}));
        end

        // Load back, then an ALU op immediately after
        load(4'd5, 32'd1032);
        run(1'b1, 1'b0, 1'b0, 4'd7, 32'h1234, 32'h0, mk(1'b1, 1'b0, 4'd7, 32'h1234, 32'h0, 1'b1, 1'b0, 1));

        // Address below the base wraps modulo 2^18 halfwords
        store(32'd0, 32'h12345678);
        if (wlog.size() == 2) begin
            check("wrap lo addr", 32'(wlog[0][33:16]), 32'h3FE00);
            check("wrap hi addr", 32'(wlog[1][33:16]), 32'h3FE01);
        end else check("wrap strobes", 32'(wlog.size()), 32'd2);
        load(4'd1, 32'd0);

        // Read and write together performs the write and forwards mem_read
        wlog.delete();
        run(1'b0, 1'b1, 1'b1, 4'd2, 32'd1040, 32'hA5A55A5A,
            mk(1'b0, 1'b1, 4'd2, 32'd1040, 32'h0, 1'b0, 1'b0, 5));
        shadow[widx(32'd1040)] = 32'hA5A55A5A;
        check("rw strobes", 32'(wlog.size()), 32'd2);
        load(4'd4, 32'd1040);

        // Misaligned load
        store(32'd1024, 32'h0BADF00D);
        wlog.delete();
`ifdef MEM_ALIGN_CHECK_EN
        run(1'b1, 1'b1, 1'b0, 4'd6, 32'd1026, 32'h0,
            mk(1'b0, 1'b1, 4'd6, 32'd1026, 32'h0, 1'b1, 1'b1, 1));
        check("misalign strobes", 32'(wlog.size()), 32'd0);
`else
        run(1'b1, 1'b1, 1'b0, 4'd6, 32'd1026, 32'h0,
            mk(1'b1, 1'b1, 4'd6, 32'd1026, 32'h0BADF00D, 1'b1, 1'b0, 5));
`endif

        // Reset in the middle of a store's LO phase
        wb_enable_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b1;
        dest_in = 4'd9; alu_res_in = 32'd1088; val_rm_in = 32'hCAFEF00D;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_write_in = 1'b0; dest_in = 4'd0; alu_res_in = 32'h0; val_rm_in = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst ready", 32'(ready), 32'd1);
        check("midrst we_n", 32'(sram_we_n), 32'd1);
        check("midrst addr", 32'(sram_addr), 32'd0);
        check("midrst outputs", {wb_enable_out, mem_read_out, align_fault, dest_out, 25'd0} | alu_res_out | mem_data_out, 32'h0);
        @(posedge clk); #1;
        load(4'd8, 32'd1032);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
